// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : requester channels and shared memory port bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0]        req_avail;
  logic [NUM_REQ-1:0]        req_r_en;
  logic [NUM_REQ-1:0]        req_w_en;
  logic [NUM_REQ*ADDR_W-1:0] req_ptr;
  logic [NUM_REQ*DATA_W-1:0] req_data_store;
  logic [NUM_REQ-1:0]        req_done;
  logic [DATA_W-1:0]         req_data_load;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  // Memory side
  logic                      mem_r_en;
  logic                      mem_w_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data_store;
  logic [DATA_W-1:0]         mem_data_load;
  logic                      mem_done;

  modport slave (
    input  req_avail, req_r_en, req_w_en, req_ptr, req_data_store,
    input  mem_data_load, mem_done,
    output req_done, req_data_load, grant_id, busy,
    output mem_r_en, mem_w_en, mem_addr, mem_data_store
  );

  modport master (
    output req_avail, req_r_en, req_w_en, req_ptr, req_data_store,
    output mem_data_load, mem_done,
    input  req_done, req_data_load, grant_id, busy,
    input  mem_r_en, mem_w_en, mem_addr, mem_data_store
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : round-robin sharing of one memory port among requesters
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst_l,
  mem_port_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0]    LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     grant_id_q;
  logic                busy_q;
  logic                mem_r_en_q;
  logic                mem_w_en_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_store_q;
  logic [NUM_REQ-1:0]  req_done_q;
  logic [DATA_W-1:0]   req_data_load_q;

  logic [NUM_REQ-1:0]  pending;
  logic                sel_found;
  logic [ID_W-1:0]     sel_id;
  logic                sel_w;
  logic [ADDR_W-1:0]   sel_ptr;
  logic [DATA_W-1:0]   sel_data;
  logic [ID_W-1:0]     rr_next;

  assign pending = bus.req_avail & (bus.req_r_en | bus.req_w_en);

  // Walk downward so the candidate closest to rr_ptr is assigned last and wins.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (pending[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx[ID_W-1:0];
      end
    end
  end

  assign sel_w    = bus.req_w_en[sel_id];
  assign sel_ptr  = bus.req_ptr[int'(sel_id)*ADDR_W +: ADDR_W];
  assign sel_data = bus.req_data_store[int'(sel_id)*DATA_W +: DATA_W];
  assign rr_next  = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= '0;
      grant_id_q       <= '0;
      busy_q           <= 1'b0;
      mem_r_en_q       <= 1'b0;
      mem_w_en_q       <= 1'b0;
      mem_addr_q       <= '0;
      mem_data_store_q <= '0;
      req_done_q       <= '0;
      req_data_load_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            // A simultaneous read and write request is treated as a write.
            mem_w_en_q       <= sel_w;
            mem_r_en_q       <= ~sel_w;
            mem_addr_q       <= sel_ptr;
            mem_data_store_q <= sel_data;
            grant_id_q       <= sel_id;
            busy_q           <= 1'b1;
            state_q          <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.mem_done) begin
            req_data_load_q <= bus.mem_data_load;
            mem_r_en_q      <= 1'b0;
            mem_w_en_q      <= 1'b0;
            req_done_q      <= ONE_HOT0 << grant_id_q;
            state_q         <= ST_RESP;
          end
        end
        ST_RESP: begin
          req_done_q <= '0;
          rr_ptr_q   <= rr_next;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          mem_r_en_q <= 1'b0;
          mem_w_en_q <= 1'b0;
          req_done_q <= '0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_done       = req_done_q;
  assign bus.req_data_load  = req_data_load_q;
  assign bus.grant_id       = grant_id_q;
  assign bus.busy           = busy_q;
  assign bus.mem_r_en       = mem_r_en_q;
  assign bus.mem_w_en       = mem_w_en_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_data_store = mem_data_store_q;

endmodule

`default_nettype wire
